// File: rtl/mips_avalon_arbiter_if.sv
// Bundle of the cache read port, the write-buffer port and the Avalon master bus
// around the MIPS memory arbiter. The arbiter uses the master modport.
interface mips_avalon_arbiter_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;

  logic        wb_empty;
  logic [31:0] wb_write_addr;
  logic [31:0] wb_write_data;
  logic [3:0]  wb_write_byteenable;
  logic        wb_write_writeenable;
  logic        wb_active;
  logic        wb_waitrequest;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    input  rd_req, rd_addr,
    input  wb_empty, wb_write_addr, wb_write_data, wb_write_byteenable, wb_write_writeenable,
    input  waitrequest, readdata,
    output rd_valid, rd_data, wb_active, wb_waitrequest,
    output address, read, write, writedata, byteenable
  );

  modport slave (
    output rd_req, rd_addr,
    output wb_empty, wb_write_addr, wb_write_data, wb_write_byteenable, wb_write_writeenable,
    output waitrequest, readdata,
    input  rd_valid, rd_data, wb_active, wb_waitrequest,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_avalon_arbiter.sv
// Arbitrates one Avalon master port between cache read misses and the write buffer.
// Reads win unless READ_STREAK_MAX consecutive reads have starved a non-empty buffer.
module mips_avalon_arbiter #(
  parameter int unsigned READ_STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_avalon_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(READ_STREAK_MAX);

  state_t      state;
  state_t      state_next;
  logic [3:0]  streak;
  logic [31:0] rd_addr_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic        rd_grant;
  logic        rd_done;
  logic        wr_done;

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next         = state;
    rd_grant           = 1'b0;
    rd_done            = 1'b0;
    wr_done            = 1'b0;
    bus.address        = '0;
    bus.read           = 1'b0;
    bus.write          = 1'b0;
    bus.writedata      = '0;
    bus.byteenable     = '0;
    bus.wb_active      = 1'b0;
    bus.wb_waitrequest = 1'b1;

    case (state)
      IDLE: begin
        if (bus.rd_req && (bus.wb_empty || streak < STREAK_MAX)) begin
          state_next = READ;
          rd_grant   = 1'b1;
        end else if (!bus.wb_empty) begin
          state_next = WRITE;
        end
      end

      READ: begin
        bus.address    = rd_addr_q;
        bus.read       = 1'b1;
        bus.byteenable = 4'hF;
        if (!bus.waitrequest) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end

      WRITE: begin
        // The buffer owns the bus here; its head entry passes straight through.
        bus.wb_active      = 1'b1;
        bus.address        = bus.wb_write_addr;
        bus.writedata      = bus.wb_write_data;
        bus.byteenable     = bus.wb_write_byteenable;
        bus.write          = bus.wb_write_writeenable;
        bus.wb_waitrequest = bus.waitrequest;
        if (bus.wb_write_writeenable && !bus.waitrequest) begin
          wr_done    = 1'b1;
          state_next = IDLE;
        end else if (bus.wb_empty && !bus.wb_write_writeenable) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      streak     <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_next;
      rd_valid_q <= rd_done;
      if (rd_grant) rd_addr_q <= bus.rd_addr;
      if (rd_done)  rd_data_q <= bus.readdata;
      // The streak only measures starvation of a buffer that actually holds data.
      if (bus.wb_empty || wr_done) begin
        streak <= '0;
      end else if (rd_done && streak < STREAK_MAX) begin
        streak <= streak + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Bench for mips_avalon_arbiter: cycle vectors for the directed corner cases, then a
// write-buffer / requester / slave model for ordering, fairness and data integrity.
module tb_mips_avalon_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_avalon_arbiter_if bus();

  mips_avalon_arbiter #(.READ_STREAK_MAX(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] J  = 32'hDEAD_BEEF;
  localparam logic [31:0] D1 = 32'h1234_5678;
  localparam logic [31:0] D2 = 32'hCAFE_F00D;

  typedef struct {
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        wb_empty;
    logic        wb_we;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_be;
    logic        waitreq;
    logic [31:0] rdata;
    logic        e_read;
    logic        e_write;
    logic        e_wba;
    logic        e_wbw;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_valid;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
    logic        has_exp;
  } rd_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [logic [31:0]];
  wr_t         wq[$];
  wr_t         wr_log[$];
  rd_t         rq[$];
  logic        exp_valid_next;
  logic [31:0] exp_data;
  int          wait_cnt;
  int          slave_delay;
  int          txn;
  bit          vary_delay;
  logic        prev_read;
  logic        prev_wba;
  logic        prev_done;
  logic [31:0] glog;
  int          gcount;
  logic [5:0]  gsnap;
  int          excl_err;
  logic [31:0] shadow [6];
  vec_t        vecs [14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] cur;
    cur = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
    mem[a] = cur;
  endfunction

  task automatic idle_inputs();
    bus.rd_req               = 1'b0;
    bus.rd_addr              = '0;
    bus.wb_empty             = 1'b1;
    bus.wb_write_addr        = '0;
    bus.wb_write_data        = '0;
    bus.wb_write_byteenable  = '0;
    bus.wb_write_writeenable = 1'b0;
    bus.waitrequest          = 1'b0;
    bus.readdata             = J;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_read"},    bus.read, 0);
    check({tag, "_write"},   bus.write, 0);
    check({tag, "_wba"},     bus.wb_active, 0);
    check({tag, "_wbw"},     bus.wb_waitrequest, 1);
    check({tag, "_address"}, bus.address, 0);
    check({tag, "_be"},      bus.byteenable, 0);
    check({tag, "_valid"},   bus.rd_valid, 0);
  endtask

  task automatic model_start();
    exp_valid_next = 1'b0;
    wait_cnt  = 0;
    txn       = 0;
    prev_read = 1'b0;
    prev_wba  = 1'b0;
    prev_done = 1'b0;
    glog      = '0;
    gcount    = 0;
    gsnap     = '0;
  endtask

  // One clock of requester, write buffer and slave behaviour around the DUT.
  task automatic model_cycle();
    @(negedge clk);
    if (bus.rd_valid || exp_valid_next) begin
      check("rd_valid", bus.rd_valid, exp_valid_next);
      if (exp_valid_next) check("rd_data", bus.rd_data, exp_data);
    end
    if (bus.rd_valid && rq.size() > 0) begin
      if (rq[0].has_exp) check($sformatf("readback_%08h", rq[0].addr), bus.rd_data, rq[0].exp);
      void'(rq.pop_front());
    end
    exp_valid_next = 1'b0;

    bus.rd_req   = (rq.size() > 0);
    bus.rd_addr  = (rq.size() > 0) ? rq[0].addr : 32'h0;
    bus.wb_empty = (wq.size() == 0);
    if (wq.size() > 0) begin
      bus.wb_write_addr       = wq[0].addr;
      bus.wb_write_data       = wq[0].data;
      bus.wb_write_byteenable = wq[0].be;
    end else begin
      bus.wb_write_addr       = '0;
      bus.wb_write_data       = '0;
      bus.wb_write_byteenable = '0;
    end
    bus.wb_write_writeenable = bus.wb_active && (wq.size() > 0);
    bus.waitrequest = 1'b0;
    bus.readdata    = J;
    #1;
    if (bus.read || bus.write) begin
      bus.waitrequest = (wait_cnt < slave_delay);
      if (bus.read && !bus.waitrequest) bus.readdata = mem_rd(bus.address);
    end
    #1;

    if (prev_done) check("idle_gap", {bus.read, bus.wb_active}, 0);
    if ((bus.read && bus.wb_active) || (bus.write && !bus.wb_active)) excl_err++;
    if ((bus.read && !prev_read) || (bus.wb_active && !prev_wba)) begin
      glog = {glog[30:0], bus.read};
      gcount++;
      if (gcount == 6) gsnap = glog[5:0];
    end

    prev_done = 1'b0;
    if (bus.read && !bus.waitrequest) begin
      exp_valid_next = 1'b1;
      exp_data       = bus.readdata;
      wait_cnt       = 0;
      prev_done      = 1'b1;
      txn++;
    end else if (bus.write && !bus.waitrequest) begin
      mem_wr(bus.address, bus.writedata, bus.byteenable);
      wr_log.push_back('{bus.address, bus.writedata, bus.byteenable});
      void'(wq.pop_front());
      wait_cnt  = 0;
      prev_done = 1'b1;
      txn++;
    end else if (bus.read || bus.write) begin
      wait_cnt++;
    end
    if (vary_delay) slave_delay = txn % 3;
    prev_read = bus.read;
    prev_wba  = bus.wb_active;
  endtask

  task automatic run_drain(input int budget, input string name);
    int n;
    n = 0;
    do begin
      model_cycle();
      n++;
    end while ((wq.size() > 0 || rq.size() > 0 || exp_valid_next || bus.read || bus.wb_active)
               && n < budget);
    check({name, "_drained"}, (n < budget), 1);
  endtask

  initial begin
    // Per-cycle vectors. Fields: rd_req rd_addr wb_empty wb_we wb_addr wb_data wb_be
    // waitreq rdata | read write wb_active wb_waitrequest address writedata be rd_valid rd_data
    vecs[0]  = '{1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 32'h0,  32'h0,  4'h0, 1'b1, J,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, J,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC0_0004, 32'h0, 4'hF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, J,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC0_0004, 32'h0, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, D1,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC0_0004, 32'h0, 4'hF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, J,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1, D1};
    vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'hA0, 32'h11, 4'h3, 1'b0, J,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, D1};
    vecs[6]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'hA0, 32'h11, 4'h3, 1'b1, J,
                 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 32'h11, 4'h3, 1'b0, D1};
    vecs[7]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'hA0, 32'h11, 4'h3, 1'b1, J,
                 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0, 32'h11, 4'h3, 1'b0, D1};
    vecs[8]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'hA0, 32'h11, 4'h3, 1'b0, J,
                 1'b0, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h11, 4'h3, 1'b0, D1};
    vecs[9]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, J,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, D1};
    vecs[10] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, D2,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 1'b0, D1};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h200, 32'h55, 4'h0, 1'b0, J,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1, D2};
    vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h55, 4'h0, 1'b1, J,
                 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h55, 4'h0, 1'b0, D2};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, J,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, D2};

    excl_err    = 0;
    vary_delay  = 1'b0;
    slave_delay = 1;
    rst = 1'b0;
    idle_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_rd_data", bus.rd_data, 0);
    rst = 1'b1;

    // Directed cycle vectors: delayed read, write stall with rd_req rising, empty-buffer abort
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.rd_req               = vecs[i].rd_req;
      bus.rd_addr              = vecs[i].rd_addr;
      bus.wb_empty             = vecs[i].wb_empty;
      bus.wb_write_writeenable = vecs[i].wb_we;
      bus.wb_write_addr        = vecs[i].wb_addr;
      bus.wb_write_data        = vecs[i].wb_data;
      bus.wb_write_byteenable  = vecs[i].wb_be;
      bus.waitrequest          = vecs[i].waitreq;
      bus.readdata             = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_read", i),    bus.read,           vecs[i].e_read);
      check($sformatf("v%0d_write", i),   bus.write,          vecs[i].e_write);
      check($sformatf("v%0d_wba", i),     bus.wb_active,      vecs[i].e_wba);
      check($sformatf("v%0d_wbw", i),     bus.wb_waitrequest, vecs[i].e_wbw);
      check($sformatf("v%0d_address", i), bus.address,        vecs[i].e_addr);
      check($sformatf("v%0d_be", i),      bus.byteenable,     vecs[i].e_be);
      check($sformatf("v%0d_valid", i),   bus.rd_valid,       vecs[i].e_valid);
      check($sformatf("v%0d_rd_data", i), bus.rd_data,        vecs[i].e_rdata);
      if (vecs[i].e_wba) check($sformatf("v%0d_wdata", i), bus.writedata, vecs[i].e_wdata);
    end

    // Reset asserted while a read is stalled
    @(negedge clk);
    idle_inputs();
    bus.rd_req      = 1'b1;
    bus.rd_addr     = 32'h300;
    bus.waitrequest = 1'b1;
    @(negedge clk);
    #1;
    check("rst_pre_read", bus.read, 1);
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_mid_read");
    @(negedge clk);
    bus.waitrequest = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_rst%0d_valid", i), bus.rd_valid, 0);
      check($sformatf("post_rst%0d_read", i),  bus.read, 0);
    end

    // Eight buffered writes, no reads: in order, one idle cycle apart
    model_start();
    wr_log.delete();
    excl_err = 0;
    for (int i = 0; i < 8; i++) wq.push_back('{32'hBFC0_0000 + 32'(i), 32'(i * i), 4'hF});
    run_drain(200, "wb8");
    check("wb8_count", wr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      check($sformatf("wb8_addr%0d", i), wr_log[i].addr, 32'hBFC0_0000 + 32'(i));
      check($sformatf("wb8_data%0d", i), wr_log[i].data, 32'(i * i));
    end
    check("wb8_excl", excl_err, 0);

    // Continuous reads against a non-empty buffer with a streak limit of two
    model_start();
    for (int i = 0; i < 4; i++) rq.push_back('{32'h400 + 32'(4 * i), 32'h0, 1'b0});
    for (int i = 0; i < 3; i++) wq.push_back('{32'h500 + 32'(4 * i), 32'h77 + 32'(i), 4'hF});
    run_drain(300, "streak");
    check("streak_grants_seen", (gcount >= 6), 1);
    check("streak_grant_seq", gsnap, 6'b110110);

    // 32 mixed transactions with varying slave delay, then read-back of every address
    model_start();
    vary_delay = 1'b1;
    slave_delay = 0;
    for (int k = 0; k < 6; k++) shadow[k] = mem_rd(32'h1000_0000 + 32'(4 * k));
    for (int i = 0; i < 20; i++) begin
      wq.push_back('{32'h1000_0000 + 32'(4 * (i % 6)), 32'hA500_0000 | 32'(i * 7), 4'hF});
      shadow[i % 6] = 32'hA500_0000 | 32'(i * 7);
    end
    for (int i = 0; i < 12; i++) rq.push_back('{32'h1000_0000 + 32'(4 * (i % 6)), 32'h0, 1'b0});
    run_drain(2000, "mixed");
    check("mixed_txn_count", txn, 32);
    vary_delay = 1'b0;
    slave_delay = 1;
    for (int k = 0; k < 6; k++) rq.push_back('{32'h1000_0000 + 32'(4 * k), shadow[k], 1'b1});
    run_drain(300, "readback");
    check("final_excl", excl_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_avalon_arbiter.md
MIPS_AVALON_ARBITER -- requirements
Module: mips_avalon_arbiter

Interface
REQ-001 SHALL have parameter: READ_STREAK_MAX, 4, max consecutive reads granted while write buffer non-empty (range 1..15).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rd_req  input  1  cache read-miss request; level, held until rd_valid.
- rd_addr  input  32  read byte address; sampled at grant.
- rd_valid  output  1  one-cycle pulse, rd_data valid.
- rd_data  output  32  registered read result.
- wb_empty  input  1  write buffer has no pending entries.
- wb_write_addr  input  32  write buffer head address.
- wb_write_data  input  32  write buffer head data.
- wb_write_byteenable  input  4  write buffer head byte enables.
- wb_write_writeenable  input  1  write buffer issuing a write.
- wb_active  output  1  grant to write buffer; buffer drives only when high.
- wb_waitrequest  output  1  waitrequest forwarded to write buffer.
- address  output  32  Avalon address.
- read  output  1  Avalon read.
- write  output  1  Avalon write.
- writedata  output  32  Avalon write data.
- byteenable  output  4  Avalon byte enables.
- waitrequest  input  1  Avalon slave stall.
- readdata  input  32  Avalon read data, valid when read high and waitrequest low.

Function
REQ-003 SHALL implement FSM IDLE, READ, WRITE; one Avalon transaction in flight, never preempted.
REQ-004 SHALL, in IDLE, drive read=0, write=0, wb_active=0, byteenable=0, address=0.
REQ-005 SHALL, in IDLE, go to READ if rd_req=1 and (wb_empty=1 or streak<READ_STREAK_MAX); else WRITE if wb_empty=0; else stay IDLE.
REQ-006 SHALL, on IDLE->READ, register rd_addr into rd_addr_q; in READ drive address=rd_addr_q, read=1, byteenable=4'b1111, write=0.
REQ-007 SHALL complete a read on a READ cycle with waitrequest=0: register readdata into rd_data, rd_valid=1 next cycle, return to IDLE.
REQ-008 SHALL, in WRITE, drive wb_active=1, address=wb_write_addr, writedata=wb_write_data, byteenable=wb_write_byteenable, write=wb_write_writeenable, read=0 (combinational pass-through).
REQ-009 SHALL forward wb_waitrequest=waitrequest in WRITE and 1 in other states.
REQ-010 SHALL complete a write on a WRITE cycle with write=1 and waitrequest=0, then return to IDLE.
REQ-011 SHALL, in WRITE, return to IDLE if wb_empty=1 and wb_write_writeenable=0 (nothing to issue).
REQ-012 SHALL keep 4-bit streak counter: +1 per completed read while wb_empty=0, saturating at READ_STREAK_MAX; cleared on each completed write or when wb_empty=1.
REQ-013 SHALL insert exactly one IDLE cycle between transactions; min read latency = grant cycle + slave wait + 1 (rd_valid).
REQ-014 SHALL ignore waitrequest and readdata in IDLE.
REQ-015 SHALL ignore rd_req deassertion mid-READ; transaction completes, rd_valid still pulses.
REQ-016 SHALL leave read-after-write hazards (read to an address pending in buffer) to the requester.

Reset
REQ-017 SHALL, on rst=0, asynchronously force state=IDLE, streak=0, rd_addr_q=0, rd_data=0, rd_valid=0, all Avalon and wb_active outputs 0, wb_waitrequest=1.
REQ-018 SHALL abandon any in-flight transaction on reset; first grant earliest one cycle after rst rises.

Verification
REQ-019 SHALL cover: single read, rd_addr=0xBFC00004, slave READ_DELAY=2, buffer empty -> read held 3 cycles, rd_valid one cycle later, rd_data=mem[0xBFC00004].
REQ-020 SHALL cover: buffer loaded with 8 writes (addr 0xBFC00000+i, data i*i), no reads -> 8 writes in order, one IDLE cycle apart, wb_active only in WRITE.
REQ-021 SHALL cover: rd_req and wb_empty=0 together, READ_STREAK_MAX=2, reads continuously requested -> grant sequence READ, READ, WRITE, READ, READ, WRITE.
REQ-022 SHALL cover: rd_req rises mid-WRITE with waitrequest=1 -> write finishes first, then IDLE, then READ.
REQ-023 SHALL cover: rst=0 during READ with waitrequest=1 -> read, write, rd_valid 0 immediately, no rd_valid after release.
REQ-024 SHALL cover: after 32 mixed transactions, read-back of all addresses -> data matches last write per address.
